// File: rtl/i2s_mic_window_if.sv
// i2s_mic_window_if: I2S pins, capture enable and sample-window outputs of the mic receiver.
interface i2s_mic_window_if #(
  parameter int DEPTH = 16,
  parameter int OUT_WIDTH = 16
);
  logic enable;
  logic DOUT;
  logic BCLK;
  logic LRCLK;
  logic new_sample;
  logic frame_ready;
  logic [DEPTH*OUT_WIDTH-1:0] window;
  modport master (input enable, DOUT, output BCLK, LRCLK, new_sample, frame_ready, window);
  modport slave (output enable, DOUT, input BCLK, LRCLK, new_sample, frame_ready, window);
endinterface

// File: rtl/i2s_mic_window.sv
// i2s_mic_window: I2S mic receiver with calibration, channel select and a newest-first sliding window.
module i2s_mic_window #(
  parameter int SLOT_BITS = 32,
  parameter int SAMPLE_BITS = 18,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int BCLK_DIV = 4,
  parameter int CAL_OFFSET = 29,
  parameter int CHANNEL_MODE = 0,
  parameter int HOP = 16
) (
  input logic clk,
  input logic reset,
  i2s_mic_window_if.master bus
);
  localparam int SB = SAMPLE_BITS;
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(SLOT_BITS);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(HOP + 1);
  localparam int WW = DEPTH * OUT_WIDTH;
  localparam int MW = OUT_WIDTH > SB ? OUT_WIDTH : SB;
  localparam int SH = OUT_WIDTH <= SB ? SB - OUT_WIDTH : 0;
  localparam logic signed [SB+1:0] OFF = (SB + 2)'(CAL_OFFSET);
  localparam logic signed [SB+1:0] MAXV = {3'b000, {(SB - 1){1'b1}}};
  localparam logic signed [SB+1:0] MINV = {3'b111, {(SB - 1){1'b0}}};
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic bclk, lrclk, done, done_ch, left_v, new_sample, frame_ready;
  logic [SB-1:0] shreg;
  logic signed [SB-1:0] left_q;
  logic [FW-1:0] fill;
  logic [HW-1:0] hop;
  logic [WW-1:0] win;
  logic tick, rise, fall, capture, push, full, fr_n;
  logic signed [SB+1:0] sum;
  logic signed [SB:0] mix_sum;
  logic signed [SB-1:0] cal, mix, pick;
  logic signed [MW-1:0] ext;
  logic [OUT_WIDTH-1:0] val;
  logic [HW-1:0] hop_n;
  always_comb begin
    tick = div_cnt == DW'(BCLK_DIV - 1);
    rise = tick && !bclk;
    fall = tick && bclk;
    capture = rise && bit_cnt != '0 && bit_cnt <= BW'(SB);
    sum = $signed({{2{shreg[SB-1]}}, shreg}) + OFF;
    cal = sum > MAXV ? MAXV[SB-1:0] : (sum < MINV ? MINV[SB-1:0] : sum[SB-1:0]);
    mix_sum = $signed({left_q[SB-1], left_q}) + $signed({cal[SB-1], cal});
    mix = SB'(mix_sum >>> 1);
    pick = CHANNEL_MODE == 2 ? mix : cal;
    ext = MW'(pick);
    val = OUT_WIDTH'(ext >>> SH);
    push = bus.enable && done &&
           (CHANNEL_MODE == 0 ? !done_ch : (CHANNEL_MODE == 1 ? done_ch : done_ch && left_v));
    full = fill == FW'(DEPTH);
    // the push that first fills the window is itself a frame boundary
    fr_n = push && (full ? hop == HW'(HOP - 1) : fill == FW'(DEPTH - 1));
    hop_n = !push ? hop : ((full && !fr_n) ? hop + HW'(1) : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk <= 1'b0;
      lrclk <= 1'b0;
      shreg <= '0;
      done <= 1'b0;
      done_ch <= 1'b0;
      left_q <= '0;
      left_v <= 1'b0;
      fill <= '0;
      hop <= '0;
      win <= '0;
      new_sample <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      new_sample <= push;
      frame_ready <= fr_n;
      hop <= hop_n;
      if (push) begin
        win <= {win[WW-OUT_WIDTH-1:0], val};
        fill <= full ? fill : fill + FW'(1);
      end
      if (!bus.enable) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk <= 1'b0;
        lrclk <= 1'b0;
        shreg <= '0;
        done <= 1'b0;
        done_ch <= 1'b0;
        left_v <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        bclk <= bclk ^ tick;
        if (fall) begin
          bit_cnt <= bit_cnt == BW'(SLOT_BITS - 1) ? '0 : bit_cnt + BW'(1);
          lrclk <= lrclk ^ (bit_cnt == BW'(SLOT_BITS - 1));
        end
        if (capture) shreg <= {shreg[SB-2:0], bus.DOUT};
        done <= rise && bit_cnt == BW'(SB);
        done_ch <= lrclk;
        if (done && !done_ch) begin
          left_q <= cal;
          left_v <= 1'b1;
        end
      end
    end
  end
  assign bus.BCLK = bclk;
  assign bus.LRCLK = lrclk;
  assign bus.new_sample = new_sample;
  assign bus.frame_ready = frame_ready;
  assign bus.window = win;
endmodule
